// File: rtl/stopwatch_core.sv
// Three-bank BCD stopwatch (ms, mm:ss, hh:mm) with a run/stop FSM, joystick direction
// control, joystick-driven bank selection and a pair-wise adjust mode.
module stopwatch_core #(
    parameter int unsigned JSTK_HI  = 800,
    parameter int unsigned JSTK_LO  = 200,
    parameter int unsigned HOLD_MAX = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_1min,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    input  logic [9:0] jstk_x,
    input  logic [9:0] jstk_y,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [1:0] mode,
    output logic       running,
    output logic       dir,
    output logic       done
);

    localparam int unsigned AccW = $clog2(HOLD_MAX + 1);
    localparam logic [AccW-1:0] AccMax  = AccW'(HOLD_MAX);
    localparam logic [AccW-1:0] AccInit = AccW'(HOLD_MAX / 2);
    localparam logic [AccW-1:0] AccQ1   = AccW'(HOLD_MAX / 4);
    localparam logic [AccW-1:0] AccQ3   = AccW'((3 * HOLD_MAX) / 4);
    localparam logic [9:0]      JHi     = 10'(JSTK_HI);
    localparam logic [9:0]      JLo     = 10'(JSTK_LO);

    typedef enum logic [1:0] {StStop, StRunUp, StRunDn} run_state_e;

    run_state_e       state_q, state_d;
    logic             dir_q, dir_d;
    logic             done_q;
    logic             expire;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0][15:0] bank_q, bank_d;
    logic [15:0]      disp_q;
    logic [15:0]      cur, nxt;
    logic [7:0]       hi_max, lo_max;
    logic             run_tick;

    // Pairs are two BCD digits {tens, ones}.
    function automatic logic [7:0] pair_inc(input logic [7:0] p, input logic [7:0] pmax);
        logic [7:0] r;
        if (p == pmax) begin
            r = 8'h00;
        end else if (p[3:0] == 4'd9) begin
            r = {p[7:4] + 4'd1, 4'd0};
        end else begin
            r = {p[7:4], p[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Only called with a nonzero pair.
    function automatic logic [7:0] pair_dec(input logic [7:0] p);
        logic [7:0] r;
        if (p[3:0] == 4'd0) begin
            r = {p[7:4] - 4'd1, 4'd9};
        end else begin
            r = {p[7:4], p[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_comb begin : bank_step
        cur      = 16'h0000;
        run_tick = 1'b0;
        hi_max   = 8'h99;
        lo_max   = 8'h59;
        case (mode_q)
            2'd0: begin
                run_tick = tick_1ms;
                lo_max   = 8'h99;
            end
            2'd1: begin
                run_tick = tick_1hz;
                hi_max   = 8'h59;
            end
            2'd2:    run_tick = tick_1min;
            default: run_tick = 1'b0;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (mode_q == 2'(i)) cur = bank_q[i];
        end
        nxt    = cur;
        expire = 1'b0;
        if (adj) begin
            if (tick_2hz) begin
                if (sel) nxt[15:8] = pair_inc(cur[15:8], hi_max);
                else     nxt[7:0]  = pair_inc(cur[7:0], lo_max);
            end
        end else if (run_tick) begin
            case (state_q)
                StRunUp: begin
                    if (cur[7:0] == lo_max) begin
                        nxt[7:0]  = 8'h00;
                        nxt[15:8] = pair_inc(cur[15:8], hi_max);
                    end else begin
                        nxt[7:0] = pair_inc(cur[7:0], lo_max);
                    end
                end
                StRunDn: begin
                    if (cur == 16'h0000) begin
                        expire = 1'b1;
                    end else if (cur[7:0] == 8'h00) begin
                        nxt[7:0]  = lo_max;
                        nxt[15:8] = pair_dec(cur[15:8]);
                    end else begin
                        nxt[7:0] = pair_dec(cur[7:0]);
                    end
                end
                default: nxt = cur;
            endcase
        end
        bank_d = bank_q;
        for (int i = 0; i < 3; i++) begin
            if (mode_q == 2'(i)) bank_d[i] = nxt;
        end
    end

    // Adjust mode freezes the run FSM; pause beats expiry, expiry beats the joystick.
    always_comb begin : fsm_next
        state_d = state_q;
        dir_d   = dir_q;
        if (!adj) begin
            if (pause) begin
                if (state_q == StStop) state_d = dir_q ? StRunUp : StRunDn;
                else                   state_d = StStop;
            end else if (expire) begin
                state_d = StStop;
            end else if (jstk_x >= JHi) begin
                state_d = StRunDn;
                dir_d   = 1'b0;
            end else if (jstk_x <= JLo) begin
                state_d = StRunUp;
                dir_d   = 1'b1;
            end
        end
    end

    always_comb begin : acc_mode_next
        acc_d = acc_q;
        if (jstk_y >= JHi && acc_q != '0) begin
            acc_d = acc_q - AccW'(1);
        end else if (jstk_y <= JLo && acc_q < AccMax) begin
            acc_d = acc_q + AccW'(1);
        end
        if (acc_q < AccQ1)      mode_d = 2'd0;
        else if (acc_q > AccQ3) mode_d = 2'd2;
        else                    mode_d = 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StStop;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
            acc_q   <= AccInit;
            mode_q  <= 2'd1;
            bank_q  <= '0;
            disp_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            done_q  <= expire;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            bank_q  <= bank_d;
            disp_q  <= cur;
        end
    end

    assign digit3  = disp_q[15:12];
    assign digit2  = disp_q[11:8];
    assign digit1  = disp_q[7:4];
    assign digit0  = disp_q[3:0];
    assign mode    = mode_q;
    assign running = (state_q != StStop);
    assign dir     = dir_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: directed scenarios plus randomized stimulus,
// checked against an arithmetic reference model of the three banks.
module tb_stopwatch_core;

    localparam int unsigned HOLD = 100;
    localparam int unsigned JHI  = 800;
    localparam int unsigned JLO  = 200;
    localparam logic [9:0]  JN   = 10'd512;
    localparam logic [3:0]  TNO  = 4'b0000;
    localparam logic [3:0]  TMS  = 4'b1000;
    localparam logic [3:0]  THZ  = 4'b0100;
    localparam logic [3:0]  T2   = 4'b0010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause = 1'b0, tick_1ms = 1'b0, tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic       tick_1min = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [9:0] jstk_x = JN, jstk_y = JN;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [1:0] mode;
    logic       running, dir, done;

    typedef struct packed {
        logic [15:0] dig;
        logic [1:0]  mode;
        logic        running;
        logic        dir;
        logic        done;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0, fails = 0, pushed = 0, popped = 0;

    // Reference model state: banks held as plain counts (ms, seconds, minutes).
    int m_state, m_dir, m_acc, m_mode;
    int m_bank[3];

    stopwatch_core #(.JSTK_HI(JHI), .JSTK_LO(JLO), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .tick_1hz(tick_1hz),
        .tick_2hz(tick_2hz), .tick_1min(tick_1min), .pause(pause), .adj(adj),
        .sel(sel), .jstk_x(jstk_x), .jstk_y(jstk_y), .digit3(digit3),
        .digit2(digit2), .digit1(digit1), .digit0(digit0), .mode(mode),
        .running(running), .dir(dir), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v, input int lm);
        int hi, lo;
        hi = v / lm;
        lo = v % lm;
        return {4'(hi / 10), 4'(hi % 10), 4'(lo / 10), 4'(lo % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_dir   = 1;
        m_acc   = HOLD / 2;
        m_mode  = 1;
        for (int i = 0; i < 3; i++) m_bank[i] = 0;
    endtask

    // state: 0 = stopped, 1 = up, 2 = down
    task automatic model_step();
        int   n, lm, hm, v, nv, hi, lo, ns, nd, nm, na;
        logic tk;
        bit   expire;
        obs_t e;
        case (m_mode)
            0:       begin n = 10000; lm = 100; hm = 100; tk = tick_1ms;  end
            1:       begin n = 3600;  lm = 60;  hm = 60;  tk = tick_1hz;  end
            default: begin n = 6000;  lm = 60;  hm = 100; tk = tick_1min; end
        endcase
        v = m_bank[m_mode];
        nv = v;
        expire = 0;
        if (adj) begin
            if (tick_2hz) begin
                hi = v / lm;
                lo = v % lm;
                if (sel) hi = (hi + 1) % hm;
                else     lo = (lo + 1) % lm;
                nv = hi * lm + lo;
            end
        end else if (tk && m_state == 1) begin
            nv = (v + 1) % n;
        end else if (tk && m_state == 2) begin
            if (v == 0) expire = 1;
            else        nv = v - 1;
        end
        ns = m_state;
        nd = m_dir;
        if (!adj) begin
            if (pause)                   ns = (m_state == 0) ? (m_dir != 0 ? 1 : 2) : 0;
            else if (expire)             ns = 0;
            else if (int'(jstk_x) >= JHI) begin ns = 2; nd = 0; end
            else if (int'(jstk_x) <= JLO) begin ns = 1; nd = 1; end
        end
        nm = (m_acc < HOLD / 4) ? 0 : ((m_acc > (3 * HOLD) / 4) ? 2 : 1);
        na = m_acc;
        if (int'(jstk_y) >= JHI && m_acc > 0)            na = m_acc - 1;
        else if (int'(jstk_y) <= JLO && m_acc < HOLD)    na = m_acc + 1;
        e.dig     = to_bcd(v, lm);
        e.mode    = 2'(nm);
        e.running = (ns != 0);
        e.dir     = (nd != 0);
        e.done    = expire;
        m_bank[m_mode] = nv;
        m_state = ns;
        m_dir   = nd;
        m_mode  = nm;
        m_acc   = na;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic p, input logic [3:0] tk, input logic a, input logic s,
                       input logic [9:0] x, input logic [9:0] y);
        pause = p;
        {tick_1ms, tick_1hz, tick_2hz, tick_1min} = tk;
        adj = a;
        sel = s;
        jstk_x = x;
        jstk_y = y;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, TNO, 1'b0, 1'b0, JN, JN);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic do_reset();
        pause = 0; {tick_1ms, tick_1hz, tick_2hz, tick_1min} = TNO;
        adj = 0; sel = 0; jstk_x = JN; jstk_y = JN;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int digs();
        return int'({digit3, digit2, digit1, digit0});
    endfunction

    // Monitor: every rising edge with a pending expectation is one comparison.
    initial begin
        obs_t act, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                act = {digit3, digit2, digit1, digit0, mode, running, dir, done};
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL outputs @%0t: got dig=%h mode=%0d running=%b dir=%b done=%b, expected dig=%h mode=%0d running=%b dir=%b done=%b",
                             $time, act.dig, act.mode, act.running, act.dir, act.done,
                             e.dig, e.mode, e.running, e.dir, e.done);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a, s, p;
        logic [3:0] tk;
        logic [9:0] x, y;
        int         yr, r;

        do_reset();
        chk("reset digits", digs(), 0);
        chk("reset mode", int'(mode), 1);
        chk("reset running", int'(running), 0);
        chk("reset dir", int'(dir), 1);
        chk("reset done", int'(done), 0);

        // Start, then 61 seconds up.
        cyc(1'b1, TNO, 1'b0, 1'b0, JN, JN);
        for (int i = 0; i < 61; i++) cyc(1'b0, THZ, 1'b0, 1'b0, JN, JN);
        idle(1);
        chk("61s digits", digs(), 16'h0101);
        chk("61s running", int'(running), 1);
        chk("61s dir", int'(dir), 1);
        chk("61s mode", int'(mode), 1);

        // Stop, then push acc up to select hh:mm and back.
        cyc(1'b1, TNO, 1'b0, 1'b0, JN, JN);
        for (int i = 0; i < 26; i++) cyc(1'b0, TNO, 1'b0, 1'b0, JN, 10'd100);
        chk("acc76 mode still 1", int'(mode), 1);
        cyc(1'b0, TNO, 1'b0, 1'b0, JN, 10'd100);
        chk("acc crossed mode 2", int'(mode), 2);
        for (int i = 0; i < 3; i++) cyc(1'b0, TNO, 1'b0, 1'b0, JN, 10'd100);
        chk("hh:mm bank shown", digs(), 0);
        for (int i = 0; i < 40; i++) cyc(1'b0, TNO, 1'b0, 1'b0, JN, 10'd900);
        chk("back to mode 1", int'(mode), 1);
        chk("mm:ss retained", digs(), 16'h0101);

        // Countdown from 00:02 to expiry.
        do_reset();
        for (int i = 0; i < 2; i++) cyc(1'b0, T2, 1'b1, 1'b0, JN, JN);
        cyc(1'b0, TNO, 1'b0, 1'b0, 10'd900, JN);
        chk("jstk down dir", int'(dir), 0);
        cyc(1'b0, THZ, 1'b0, 1'b0, JN, JN);
        idle(1);
        chk("down 00:01", digs(), 16'h0001);
        cyc(1'b0, THZ, 1'b0, 1'b0, JN, JN);
        idle(1);
        chk("down 00:00", digs(), 16'h0000);
        cyc(1'b0, THZ, 1'b0, 1'b0, JN, JN);
        chk("expiry done", int'(done), 1);
        chk("expiry stops", int'(running), 0);
        idle(1);
        chk("done one cycle", int'(done), 0);
        chk("expired stays 0", digs(), 0);

        // Adjust wraps without carry.
        do_reset();
        for (int i = 0; i < 59; i++) cyc(1'b0, T2, 1'b1, 1'b0, JN, JN);
        idle(1);
        chk("adj lo 59", digs(), 16'h0059);
        cyc(1'b0, T2, 1'b1, 1'b0, JN, JN);
        idle(1);
        chk("adj lo wrap no carry", digs(), 16'h0000);
        for (int i = 0; i < 60; i++) cyc(1'b0, T2, 1'b1, 1'b1, JN, JN);
        idle(1);
        chk("adj hi wrap", digs(), 16'h0000);

        // 59:59 rollover coincident with pause, then asynchronous reset.
        do_reset();
        for (int i = 0; i < 59; i++) cyc(1'b0, T2, 1'b1, 1'b1, JN, JN);
        for (int i = 0; i < 59; i++) cyc(1'b0, T2, 1'b1, 1'b0, JN, JN);
        cyc(1'b1, TNO, 1'b0, 1'b0, JN, JN);
        chk("59:59 shown", digs(), 16'h5959);
        cyc(1'b1, THZ, 1'b0, 1'b0, JN, JN);
        idle(1);
        chk("rollover 00:00", digs(), 16'h0000);
        chk("pause stopped", int'(running), 0);
        cyc(1'b1, TNO, 1'b0, 1'b0, JN, JN);
        for (int i = 0; i < 3; i++) cyc(1'b0, THZ, 1'b0, 1'b0, JN, 10'd100);
        idle(1);
        chk("pre-reset count", digs(), 16'h0003);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst digits", digs(), 0);
        chk("async rst running", int'(running), 0);
        chk("async rst mode", int'(mode), 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, THZ, 1'b0, 1'b0, JN, JN);
        chk("no count without start", digs(), 0);

        // Randomized segments; no start/stop activity while adjusting.
        for (int seg = 0; seg < 60; seg++) begin
            a  = ($urandom_range(0, 5) == 0);
            s  = 1'($urandom_range(0, 1));
            yr = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                p  = !a && ($urandom_range(0, 29) == 0);
                tk = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
                r  = $urandom_range(0, 24);
                if (a)           x = JN;
                else if (r == 0) x = 10'($urandom_range(JHI, 1023));
                else if (r == 1) x = 10'($urandom_range(0, JLO));
                else             x = 10'($urandom_range(JLO + 1, JHI - 1));
                if (yr == 0)      y = 10'($urandom_range(0, JLO));
                else if (yr == 1) y = 10'($urandom_range(JHI, 1023));
                else              y = 10'($urandom_range(JLO + 1, JHI - 1));
                cyc(p, tk, a, s, x, y);
            end
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        chk("all expectations compared", popped, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter JSTK_HI, default 800, joystick axis value at or above which the axis counts as deflected high.
REQ-002 Parameter JSTK_LO, default 200, joystick axis value at or below which the axis counts as deflected low.
REQ-003 Parameter HOLD_MAX, default 50_000_000, full-scale value of the mode-select accumulator.
REQ-004 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tick_1ms, tick_1hz, tick_2hz, tick_1min  in  1 each  single-cycle count enables synchronous to clk.
REQ-007 pause  in  1  single-cycle pulse; toggles run/stop.
REQ-008 adj  in  1  level; adjust mode.
REQ-009 sel  in  1  level; adjust target, 1 = high digit pair, 0 = low digit pair.
REQ-010 jstk_x, jstk_y  in  10 each  joystick position.
REQ-011 digit3, digit2, digit1, digit0  out  4 each  registered BCD display digits, digit3 most significant.
REQ-012 mode  out  2  registered; 0 = ms bank, 1 = mm:ss bank, 2 = hh:mm bank.
REQ-013 running  out  1  high in RUN_UP or RUN_DN.
REQ-014 dir  out  1  1 = counting up, 0 = counting down.
REQ-015 done  out  1  single-cycle pulse on countdown expiry.

Function
REQ-016 Tick inputs are enables only; no logic shall be clocked by anything other than clk.
REQ-017 Run FSM states: STOP, RUN_UP, RUN_DN; pause in STOP -> RUN state matching dir; pause in RUN_* -> STOP.
REQ-018 Without pause: jstk_x >= JSTK_HI -> RUN_DN, dir=0; jstk_x <= JSTK_LO -> RUN_UP, dir=1; pause wins over joystick in the same cycle.
REQ-019 Accumulator acc (range 0..HOLD_MAX): jstk_y >= JSTK_HI and acc > 0 -> decrement by 1; jstk_y <= JSTK_LO and acc < HOLD_MAX -> increment by 1; saturates at both ends.
REQ-020 mode updates one cycle after acc: 0 if acc < HOLD_MAX/4, 2 if acc > 3*HOLD_MAX/4, else 1.
REQ-021 Three independent banks, each holding four BCD digits: ms bank 0000-9999 on tick_1ms; mm:ss bank high pair 00-59, low pair 00-59 on tick_1hz; hh:mm bank high pair 00-99, low pair 00-59 on tick_1min.
REQ-022 Only the bank selected by the current mode register advances; other banks hold their value, and the value is retained across mode switches.
REQ-023 RUN_UP on tick: low pair +1; low pair at max -> 00 with carry into high pair; high pair at max -> 00 (full rollover, e.g. 59:59 -> 00:00); ms bank 9999 -> 0000.
REQ-024 RUN_DN on tick: low pair -1; low pair at 00 -> max with borrow from high pair.
REQ-025 RUN_DN tick with active bank at 0000: bank stays 0000, done pulses for 1 cycle, FSM -> STOP next cycle.
REQ-026 adj=1 overrides running: run ticks are ignored, FSM state is retained, and the active bank advances up on tick_2hz for the pair chosen by sel, wrapping at that pair's max with no carry into the other pair (ms bank: sel=1 -> digits3:2, sel=0 -> digits1:0, each 00-99).
REQ-027 Digit outputs equal the active bank delayed by 1 cycle; a mode change is visible on the digits 1 cycle after mode updates.
REQ-028 Tick coincident with a mode change: the tick applies to the bank selected by the pre-update mode.
REQ-029 Tick coincident with pause: the tick is applied per the FSM state before the transition.

Reset
REQ-030 rst asserted asynchronously forces: all bank digits 0, acc = HOLD_MAX/2, mode = 1, FSM = STOP, dir = 1, done = 0, all digit outputs 0.
REQ-031 Reset mid-count discards all bank contents; counting resumes only after rst deasserts and a start event (pause or jstk_x) occurs.

Verification
REQ-032 Reset, pause pulse, 61 tick_1hz -> digits 0,1,0,1 (01:01), running=1, dir=1, mode=1.
REQ-033 mm:ss at 00:02, jstk_x=900, 3 tick_1hz -> 00:01, then 00:00, then done pulse and running=0; digits stay 00:00.
REQ-034 HOLD_MAX=100: jstk_y=100 held 30 cycles -> acc=80, mode=2 on the cycle after acc crosses 75; returning to mode=1 shows the retained mm:ss value.
REQ-035 adj=1, sel=0, mm:ss at 00:59, 1 tick_2hz -> 00:00 (no carry); sel=1 at 59:00 -> 00:00.
REQ-036 Running at 59:59 up, tick_1hz together with pause -> 00:00 and STOP; rst asserted mid-run -> outputs 0 immediately, without waiting for a clk edge.
